logic_issue_stage: RTL and testbench

//   Initiator side of the logic-unit interface: accepts a logic-op request (func, A, B, dest reg),

---
 rtl/logic_issue_stage.sv | 157 +++++++++++++++
 tb/tb_logic_issue_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_issue_stage.sv
// logic_issue_stage: execute-stage initiator for a combinational logic unit.
// Each request is decoded to a 2-bit logic function and registered operands.
// The result is captured after one full cycle and returned with zero/neg/illegal
// flags on a valid/ready response channel. Completed handshakes are counted.
module logic_issue_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_func,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [RD_W-1:0]  req_rd,
  output logic [WIDTH-1:0] lu_x,
  output logic [WIDTH-1:0] lu_y,
  output logic [1:0]       lu_fn,
  input  logic [WIDTH-1:0] lu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [RD_W-1:0]  rsp_rd,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] ops_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] lu_x_q, lu_y_q, rsp_data_q;
  logic [1:0]       lu_fn_q;
  logic [RD_W-1:0]  rd_q, rsp_rd_q;
  logic             illegal_q;
  logic             rsp_valid_q, rsp_zero_q, rsp_neg_q, rsp_illegal_q;
  logic [CNT_W-1:0] ops_count_q;

  logic             dec_legal, dec_use_b;
  logic [1:0]       dec_fn;
  logic [WIDTH-1:0] lu_x_d, lu_y_d, cap_d;
  logic [1:0]       lu_fn_d;

  // Returns {legal, use_b, fn}. Unary ops pair operand A with a zero second operand.
  function automatic logic [3:0] decode_func(input logic [3:0] func);
    logic [3:0] r;
    case (func)
      4'd0:    r = {1'b1, 1'b1, 2'b00};  // AND
      4'd1:    r = {1'b1, 1'b1, 2'b01};  // OR
      4'd2:    r = {1'b1, 1'b1, 2'b10};  // XOR
      4'd3:    r = {1'b1, 1'b1, 2'b11};  // NOR
      4'd4:    r = {1'b1, 1'b0, 2'b11};  // NOT a  = NOR(a,0)
      4'd5:    r = {1'b1, 1'b0, 2'b01};  // MOV a  = OR(a,0)
      4'd6:    r = {1'b1, 1'b0, 2'b00};  // CLR    = AND(a,0)
      default: r = {1'b0, 1'b0, 2'b00};  // illegal
    endcase
    return r;
  endfunction

  // Decode the incoming request; illegal codes leave the logic-unit operands untouched.
  always_comb begin
    {dec_legal, dec_use_b, dec_fn} = decode_func(req_func);
    if (dec_legal) begin
      lu_x_d  = req_a;
      lu_y_d  = dec_use_b ? req_b : {WIDTH{1'b0}};
      lu_fn_d = dec_fn;
    end else begin
      lu_x_d  = lu_x_q;
      lu_y_d  = lu_y_q;
      lu_fn_d = lu_fn_q;
    end
    cap_d = illegal_q ? {WIDTH{1'b0}} : lu_result;
  end

  // Ready while idle, or while the pending response is being consumed this cycle.
  assign req_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready);

  // Control FSM with all datapath and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lu_x_q        <= {WIDTH{1'b0}};
      lu_y_q        <= {WIDTH{1'b0}};
      lu_fn_q       <= 2'b00;
      rd_q          <= {RD_W{1'b0}};
      illegal_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= {WIDTH{1'b0}};
      rsp_rd_q      <= {RD_W{1'b0}};
      rsp_zero_q    <= 1'b0;
      rsp_neg_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
      ops_count_q   <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            lu_x_q    <= lu_x_d;
            lu_y_q    <= lu_y_d;
            lu_fn_q   <= lu_fn_d;
            rd_q      <= req_rd;
            illegal_q <= ~dec_legal;
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_q    <= cap_d;
          rsp_zero_q    <= (cap_d == {WIDTH{1'b0}});
          rsp_neg_q     <= cap_d[WIDTH-1];
          rsp_rd_q      <= rd_q;
          rsp_illegal_q <= illegal_q;
          rsp_valid_q   <= 1'b1;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            ops_count_q <= ops_count_q + CNT_W'(1);
            rsp_valid_q <= 1'b0;
            if (req_valid) begin
              lu_x_q    <= lu_x_d;
              lu_y_q    <= lu_y_d;
              lu_fn_q   <= lu_fn_d;
              rd_q      <= req_rd;
              illegal_q <= ~dec_legal;
              state_q   <= ST_EXEC;
            end else begin
              state_q   <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign lu_x        = lu_x_q;
  assign lu_y        = lu_y_q;
  assign lu_fn       = lu_fn_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_neg     = rsp_neg_q;
  assign rsp_illegal = rsp_illegal_q;
  assign ops_count   = ops_count_q;

endmodule

// File: tb/tb_logic_issue_stage.sv
// Testbench for logic_issue_stage: directed table, backpressure/back-to-back and
// mid-operation reset sequences, then randomized requests against a reference model.
// A second instance with a 4-bit counter exercises counter wrap-around quickly.
module tb_logic_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, rsp_ready;
  logic [3:0]  req_func;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        req_ready, rsp_valid, rsp_zero, rsp_neg, rsp_illegal;
  logic [31:0] lu_x, lu_y, lu_result, rsp_data;
  logic [1:0]  lu_fn;
  logic [4:0]  rsp_rd;
  logic [15:0] ops_count;

  logic        s_req_ready, s_rsp_valid, s_rsp_zero, s_rsp_neg, s_rsp_illegal;
  logic [31:0] s_lu_x, s_lu_y, s_rsp_data;
  logic [1:0]  s_lu_fn;
  logic [4:0]  s_rsp_rd;
  logic [3:0]  s_ops_count;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: last legal logic-unit programming and number of handshakes.
  logic [31:0] m_lu_x, m_lu_y;
  logic [1:0]  m_lu_fn;
  int          m_ops;

  always #5 clk = ~clk;

  logic_issue_stage #(.WIDTH(32), .RD_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .lu_x(lu_x), .lu_y(lu_y), .lu_fn(lu_fn), .lu_result(lu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
    .rsp_illegal(rsp_illegal), .ops_count(ops_count)
  );

  logic_issue_stage #(.WIDTH(32), .RD_W(5), .CNT_W(4)) u_dut_small (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_func(req_func), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .lu_x(s_lu_x), .lu_y(s_lu_y), .lu_fn(s_lu_fn), .lu_result(lu_result),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
    .rsp_rd(s_rsp_rd), .rsp_zero(s_rsp_zero), .rsp_neg(s_rsp_neg),
    .rsp_illegal(s_rsp_illegal), .ops_count(s_ops_count)
  );

  // Combinational logic unit seen by the stage.
  always_comb begin
    case (lu_fn)
      2'b00:   lu_result = lu_x & lu_y;
      2'b01:   lu_result = lu_x | lu_y;
      2'b10:   lu_result = lu_x ^ lu_y;
      default: lu_result = ~(lu_x | lu_y);
    endcase
  end

  // Architectural meaning of each operation code.
  function automatic logic [31:0] ref_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return ~(a | b);
      4'd4:    return ~a;
      4'd5:    return a;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_accept(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f <= 4'd6) begin
      m_lu_x = a;
      m_lu_y = (f < 4'd4) ? b : 32'h0;
      case (f)
        4'd4:    m_lu_fn = 2'b11;
        4'd5:    m_lu_fn = 2'b01;
        4'd6:    m_lu_fn = 2'b00;
        default: m_lu_fn = f[1:0];
      endcase
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] exp, input logic [4:0] rd, input logic ill);
    chk({tag, "_valid"},   32'(rsp_valid), 32'd1);
    chk({tag, "_data"},    rsp_data, exp);
    chk({tag, "_rd"},      32'(rsp_rd), 32'(rd));
    chk({tag, "_zero"},    32'(rsp_zero), 32'(exp == 32'h0));
    chk({tag, "_neg"},     32'(rsp_neg), 32'(exp[31]));
    chk({tag, "_illegal"}, 32'(rsp_illegal), 32'(ill));
  endtask

  task automatic chk_count(input string tag);
    chk({tag, "_ops"},       32'(ops_count), 32'(m_ops & 32'hFFFF));
    chk({tag, "_ops_small"}, 32'(s_ops_count), 32'(m_ops & 32'hF));
  endtask

  // One complete transaction starting and ending in the idle state (at #1 after an edge).
  task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int stall);
    req_valid = 1'b1; req_func = f; req_a = a; req_b = b; req_rd = rd; rsp_ready = 1'b0;
    #1 chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    model_accept(f, a, b);
    @(posedge clk); #1;
    req_valid = 1'b0; req_func = 4'($urandom); req_a = $urandom; req_b = $urandom;
    chk({tag, "_lu_x"}, lu_x, m_lu_x);
    chk({tag, "_lu_y"}, lu_y, m_lu_y);
    chk({tag, "_lu_fn"}, 32'(lu_fn), 32'(m_lu_fn));
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk_rsp(tag, exp, rd, f > 4'd6);
    chk_count(tag);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_data"}, rsp_data, exp);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 chk({tag, "_resp_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    m_ops++;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk_count(tag);
  endtask

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'd2,  32'hF0F0_F0F0, 32'hFFFF_0000, 5'd7,  32'h0F0F_F0F0, 0};
    tbl[1] = '{4'd4,  32'h0000_0000, 32'h1234_5678, 5'd3,  32'hFFFF_FFFF, 1};
    tbl[2] = '{4'd6,  32'hDEAD_BEEF, 32'h0000_0001, 5'd1,  32'h0000_0000, 0};
    tbl[3] = '{4'd9,  32'h0000_1234, 32'h0000_5555, 5'd9,  32'h0000_0000, 2};
    tbl[4] = '{4'd0,  32'hFF00_FF00, 32'h0F0F_0F0F, 5'd2,  32'h0F00_0F00, 0};
    tbl[5] = '{4'd1,  32'h8000_0000, 32'h0000_0001, 5'd31, 32'h8000_0001, 0};
    tbl[6] = '{4'd3,  32'hF0F0_F0F0, 32'h0F0F_0F00, 5'd4,  32'h0000_000F, 0};
    tbl[7] = '{4'd5,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 0};
    tbl[8] = '{4'd15, 32'h0000_0000, 32'h0000_0000, 5'd5,  32'h0000_0000, 0};

    m_lu_x = 32'h0; m_lu_y = 32'h0; m_lu_fn = 2'b00; m_ops = 0;
    req_valid = 1'b0; rsp_ready = 1'b0; req_func = 4'd0; req_a = 32'h0; req_b = 32'h0; req_rd = 5'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_lu_x", lu_x, 32'h0);
    chk("rst_lu_y", lu_y, 32'h0);
    chk("rst_lu_fn", 32'(lu_fn), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_flags", 32'({rsp_rd, rsp_zero, rsp_neg, rsp_illegal}), 32'd0);
    chk_count("rst");
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 9; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].stall);

    // Backpressure for five cycles, then back-to-back accept during the handshake.
    req_valid = 1'b1; req_func = 4'd0; req_a = 32'hFFFF_0000; req_b = 32'h1234_5678; req_rd = 5'd10;
    model_accept(4'd0, 32'hFFFF_0000, 32'h1234_5678);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk_rsp("bp1", 32'h1234_0000, 5'd10, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      chk_rsp("bp1_hold", 32'h1234_0000, 5'd10, 1'b0);
      chk("bp1_hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b1; req_func = 4'd1; req_a = 32'h0000_00F0; req_b = 32'h0000_0F00; req_rd = 5'd11;
    rsp_ready = 1'b1;
    #1 chk("b2b_ready", 32'(req_ready), 32'd1);
    model_accept(4'd1, 32'h0000_00F0, 32'h0000_0F00);
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0; m_ops++;
    chk("b2b_exec_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_lu_fn", 32'(lu_fn), 32'(m_lu_fn));
    chk("b2b_lu_y", lu_y, m_lu_y);
    chk_count("b2b_first");
    @(posedge clk); #1;
    chk_rsp("b2b", 32'h0000_0FF0, 5'd11, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; m_ops++;
    chk_count("b2b_second");

    // Reset pulse while an operation is in EXEC.
    req_valid = 1'b1; req_func = 4'd2; req_a = 32'hAAAA_5555; req_b = 32'h0F0F_0F0F; req_rd = 5'd21;
    @(posedge clk); #1 req_valid = 1'b0;
    rst = 1'b1;
    #1;
    m_lu_x = 32'h0; m_lu_y = 32'h0; m_lu_fn = 2'b00; m_ops = 0;
    chk("mid_rst_lu_x", lu_x, 32'h0);
    chk("mid_rst_lu_fn", 32'(lu_fn), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk_count("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_data", rsp_data, 32'h0);
    end
    chk_count("post_rst");

    // Randomized requests; the 4-bit counter instance wraps several times.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f  = 4'($urandom_range(15, 0));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(31, 0));
      if (i % 5 == 0) a = 32'h0;
      run_op($sformatf("rnd%0d", i), f, a, b, rd, ref_op(f, a, b), int'($urandom_range(2, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
